// File: rtl/guess_checker_if.sv
// Bus between the guessing-game checker and its neighbours (load register, switches, display).
// The two strobes have no ready: every secret_load/guess_btn pulse is taken or dropped by state rules.
interface guess_checker_if #(
  parameter int DATA_W = 4,
  parameter int TRY_W  = 3
);
  logic [DATA_W-1:0] secret;
  logic              secret_load;
  logic [DATA_W-1:0] guess;
  logic              guess_btn;
  logic              too_high;
  logic              too_low;
  logic              correct;
  logic              win;
  logic              lose;
  logic [TRY_W-1:0]  tries_left;
  logic              busy;
  logic [1:0]        state_dbg;

  modport master (
    output secret, secret_load, guess, guess_btn,
    input  too_high, too_low, correct, win, lose, tries_left, busy, state_dbg
  );

  modport slave (
    input  secret, secret_load, guess, guess_btn,
    output too_high, too_low, correct, win, lose, tries_left, busy, state_dbg
  );
endinterface

// File: rtl/guess_checker.sv
// Guess checker: freezes a secret on secret_load, then grades up to MAX_TRIES guesses.
// Define GUESS_HINT_EN to drive too_high/too_low; otherwise they stay 0 and no magnitude compare exists.
module guess_checker #(
  parameter int DATA_W    = 4,
  parameter int MAX_TRIES = 4,
  parameter int TRY_W     = 3
) (
  input logic             clk,
  input logic             rst,
  guess_checker_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ARMED, WON, LOST} state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_secret;
  logic [TRY_W-1:0]    r_tries;
  logic                r_too_high;
  logic                r_too_low;
  logic                r_correct;
  logic                r_win;
  logic                r_lose;
  logic                r_busy;

  state_t              w_state_nxt;
  logic [DATA_W-1:0]   w_secret_nxt;
  logic [TRY_W-1:0]    w_tries_nxt;
  logic                w_too_high_nxt;
  logic                w_too_low_nxt;
  logic                w_correct_nxt;
  logic                w_win_nxt;
  logic                w_lose_nxt;
  logic                w_eq;
  logic                w_gt;
  logic                w_lt;

  assign w_eq = (bus.guess == r_secret);
`ifdef GUESS_HINT_EN
  assign w_gt = (bus.guess > r_secret);
  assign w_lt = (bus.guess < r_secret);
`else
  assign w_gt = 1'b0;
  assign w_lt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_secret   <= '0;
      r_tries    <= '0;
      r_too_high <= 1'b0;
      r_too_low  <= 1'b0;
      r_correct  <= 1'b0;
      r_win      <= 1'b0;
      r_lose     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_secret   <= w_secret_nxt;
      r_tries    <= w_tries_nxt;
      r_too_high <= w_too_high_nxt;
      r_too_low  <= w_too_low_nxt;
      r_correct  <= w_correct_nxt;
      r_win      <= w_win_nxt;
      r_lose     <= w_lose_nxt;
      r_busy     <= (w_state_nxt == ARMED);
    end
  end

  // secret_load outranks a same-cycle guess in every state, including mid-game restarts.
  always_comb begin
    w_state_nxt    = r_state;
    w_secret_nxt   = r_secret;
    w_tries_nxt    = r_tries;
    w_too_high_nxt = r_too_high;
    w_too_low_nxt  = r_too_low;
    w_correct_nxt  = r_correct;
    w_win_nxt      = r_win;
    w_lose_nxt     = r_lose;
    if (bus.secret_load) begin
      w_state_nxt    = ARMED;
      w_secret_nxt   = bus.secret;
      w_tries_nxt    = TRY_W'(MAX_TRIES);
      w_too_high_nxt = 1'b0;
      w_too_low_nxt  = 1'b0;
      w_correct_nxt  = 1'b0;
      w_win_nxt      = 1'b0;
      w_lose_nxt     = 1'b0;
    end else if (r_state == ARMED && bus.guess_btn) begin
      w_tries_nxt    = (r_tries != '0) ? r_tries - TRY_W'(1) : '0;
      w_too_high_nxt = w_gt;
      w_too_low_nxt  = w_lt;
      w_correct_nxt  = w_eq;
      if (w_eq) begin
        w_win_nxt   = 1'b1;
        w_state_nxt = WON;
      end else if (r_tries <= TRY_W'(1)) begin
        w_lose_nxt  = 1'b1;
        w_state_nxt = LOST;
      end
    end
  end

  assign bus.too_high   = r_too_high;
  assign bus.too_low    = r_too_low;
  assign bus.correct    = r_correct;
  assign bus.win        = r_win;
  assign bus.lose       = r_lose;
  assign bus.tries_left = r_tries;
  assign bus.busy       = r_busy;
  assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_guess_checker.sv
// Bench for guess_checker: directed game scenarios then random strobes, scored against a game model.
module tb_guess_checker;

  localparam int DATA_W    = 4;
  localparam int MAX_TRIES = 4;
  localparam int TRY_W     = 3;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_err;

  logic [8:0] exp_q[$];

  // game model: 0 = no game, 1 = playing, 2 = won, 3 = lost
  int m_game;
  int m_secret;
  int m_tries;
  bit m_hi, m_lo, m_eq, m_win, m_lose;

  guess_checker_if #(.DATA_W(DATA_W), .TRY_W(TRY_W)) bus ();

  guess_checker #(
    .DATA_W(DATA_W), .MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step(input bit rstn, input bit sl, input int sec,
                                     input bit gb, input int g);
    if (!rstn) begin
      m_game = 0; m_secret = 0; m_tries = 0;
      {m_hi, m_lo, m_eq, m_win, m_lose} = '0;
    end else if (sl) begin
      m_game = 1; m_secret = sec; m_tries = MAX_TRIES;
      {m_hi, m_lo, m_eq, m_win, m_lose} = '0;
    end else if (gb && m_game == 1) begin
      m_tries = m_tries - 1;
`ifdef GUESS_HINT_EN
      m_hi = (g > m_secret);
      m_lo = (g < m_secret);
`else
      m_hi = 1'b0;
      m_lo = 1'b0;
`endif
      m_eq = (g == m_secret);
      if (m_eq) begin
        m_win = 1'b1; m_game = 2;
      end else if (m_tries == 0) begin
        m_lose = 1'b1; m_game = 3;
      end
    end
  endfunction

  function automatic logic [8:0] model_pack();
    logic [2:0] t;
    t = 3'(m_tries);
    return {m_hi, m_lo, m_eq, m_win, m_lose, t, (m_game == 1)};
  endfunction

  task automatic compare();
    logic [8:0] e;
    e = exp_q.pop_front();
    check("too_high",   32'(bus.too_high),   32'(e[8]));
    check("too_low",    32'(bus.too_low),    32'(e[7]));
    check("correct",    32'(bus.correct),    32'(e[6]));
    check("win",        32'(bus.win),        32'(e[5]));
    check("lose",       32'(bus.lose),       32'(e[4]));
    check("tries_left", 32'(bus.tries_left), 32'(e[3:1]));
    check("busy",       32'(bus.busy),       32'(e[0]));
  endtask

  // driver: apply one cycle of inputs, score outputs just after the edge
  task automatic cycle(input bit rstn, input bit sl, input logic [3:0] sec,
                       input bit gb, input logic [3:0] g);
    rst             = rstn;
    bus.secret_load = sl;
    bus.secret      = sec;
    bus.guess_btn   = gb;
    bus.guess       = g;
    @(posedge clk);
    model_step(rstn, sl, int'(sec), gb, int'(g));
    exp_q.push_back(model_pack());
    #1;
    compare();
    bus.secret_load = 1'b0;
    bus.guess_btn   = 1'b0;
  endtask

  task automatic load(input logic [3:0] sec);
    cycle(1'b1, 1'b1, sec, 1'b0, 4'd0);
  endtask

  task automatic guess_with_bus(input logic [3:0] sec_bus, input logic [3:0] g);
    cycle(1'b1, 1'b0, sec_bus, 1'b1, g);
  endtask

  initial begin
    logic [3:0] wrong[4];
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.secret = '0; bus.secret_load = 1'b0; bus.guess = '0; bus.guess_btn = 1'b0;

    cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    cycle(1'b0, 1'b0, 4'd0, 1'b0, 4'd0);
    guess_with_bus(4'd0, 4'b0011);

    load(4'b1001);
    guess_with_bus(4'b1001, 4'b0100);
    guess_with_bus(4'b1001, 4'b1100);
    guess_with_bus(4'b1001, 4'b1001);
    guess_with_bus(4'b1001, 4'b0001);

    wrong = '{4'b0000, 4'b1111, 4'b0001, 4'b1110};
    load(4'b0110);
    for (int i = 0; i < 4; i++) guess_with_bus(4'b0110, wrong[i]);
    guess_with_bus(4'b0110, 4'b0110);

    load(4'b0101);
    guess_with_bus(4'b0101, 4'b0011);
    guess_with_bus(4'b0101, 4'b1000);
    guess_with_bus(4'b0000, 4'b0000);
    cycle(1'b1, 1'b1, 4'b0111, 1'b1, 4'b0111);
    guess_with_bus(4'b0000, 4'b0001);
    guess_with_bus(4'b0000, 4'b0010);
    guess_with_bus(4'b0000, 4'b0011);
    cycle(1'b0, 1'b0, 4'd0, 1'b1, 4'b0111);
    guess_with_bus(4'd0, 4'd0);

    // held button: one guess per high cycle
    load(4'b1010);
    for (int i = 0; i < 3; i++) guess_with_bus(4'b1010, 4'b0010);

    for (int i = 0; i < 600; i++) begin
      bit         rn, sl, gb;
      logic [3:0] sec, g;
      rn  = ($urandom_range(0, 49) != 0);
      sl  = ($urandom_range(0, 9) == 0);
      gb  = ($urandom_range(0, 2) != 0);
      sec = 4'($urandom_range(0, 15));
      g   = ($urandom_range(0, 3) == 0) ? 4'(m_secret) : 4'($urandom_range(0, 15));
      cycle(rn, sl, sec, gb, g);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
